// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory: packs bytes big-endian into words,
// writes them to consecutive addresses, holds the CPU off and keeps a running word checksum.
module imem_loader #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] checksum_o
);

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] sum_q, sum_d;

    // Next-state and datapath; byte_ready is high exactly in RECV, so valid alone means a transfer there.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sum_d = '0;
                    if (len_i != '0) begin
                        base_d  = base_addr_i;
                        len_d   = len_i;
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = S_RECV;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RECV: begin
                if (byte_valid_i) begin
                    word_d = {word_q[DATA_W-BYTE_W-1:0], byte_data_i};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        addr_d  = ADDR_W'(base_q + idx_q);
                        data_d  = word_d;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                sum_d   = sum_q + data_q;
                idx_d   = idx_q + ADDR_W'(1);
                state_d = (idx_q == ADDR_W'(len_q - ADDR_W'(1))) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
        end
    end

    // Control outputs are pure decodes of the state register.
    assign byte_ready_o = (state_q == S_RECV);
    assign mem_we_o     = (state_q == S_WRITE);
    assign done_o       = (state_q == S_DONE);
    assign busy_o       = (state_q != S_IDLE);
    assign cpu_hold_o   = (state_q != S_IDLE);
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;
    assign checksum_o   = sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random loads compared against
// a word-list model of the image, with a sparse memory standing in for the ifetch side.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] base_addr_i;
    logic [15:0] len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        cpu_hold_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] checksum_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          done_cnt = 0;
    int          inv_err  = 0;
    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [31:0] tbmem[int];
    logic [7:0]  img[$];

    imem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .byte_valid_i(byte_valid_i),
        .byte_data_i (byte_data_i),
        .byte_ready_o(byte_ready_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .cpu_hold_o  (cpu_hold_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .checksum_o  (checksum_o)
    );

    always #5 clk = ~clk;

    // Write monitor: stands in for the memory and records every write with its cycle.
    always @(negedge clk) begin
        cycle++;
        if (mem_we_o === 1'b1) begin
            wr_addr.push_back(mem_addr_o);
            wr_data.push_back(mem_data_o);
            wr_cyc.push_back(cycle);
            tbmem[int'(mem_addr_o)] = mem_data_o;
        end
        if (done_o === 1'b1) done_cnt++;
        if (busy_o !== cpu_hold_o) inv_err++;
        if (mem_we_o === 1'b1 && byte_ready_o === 1'b1) inv_err++;
        if (byte_ready_o === 1'b1 && busy_o !== 1'b1) inv_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic make_img(input int nwords);
        img.delete();
        for (int i = 0; i < 4 * nwords; i++) img.push_back(8'($urandom));
    endtask

    // Drives one load; gap<0 picks a random 0..2 idle cycles before each byte.
    task automatic run_load(input logic [15:0] base, input logic [15:0] len,
                            input int gap, input bit mid_start, input string tag);
        int idx    = 0;
        int cyc    = 0;
        int wait_n = (gap < 0) ? int'($urandom_range(2)) : gap;
        bit seen   = 1'b0;
        clear_log();
        start_i      = 1'b1;
        base_addr_i  = base;
        len_i        = len;
        byte_valid_i = 1'b0;
        @(negedge clk);
        if (done_o === 1'b1) seen = 1'b1;
        while (!seen && cyc < 2000) begin
            if (mid_start && cyc == 3) begin
                start_i     = 1'b1;
                base_addr_i = ~base;
                len_i       = len + 16'd5;
            end else begin
                start_i = 1'b0;
            end
            if (idx < img.size() && wait_n == 0) begin
                byte_valid_i = 1'b1;
                byte_data_i  = img[idx];
                if (byte_ready_o === 1'b1) begin
                    idx++;
                    wait_n = (gap < 0) ? int'($urandom_range(2)) : gap;
                end
            end else begin
                byte_valid_i = 1'b0;
                byte_data_i  = 8'($urandom);
                if (wait_n > 0) wait_n--;
            end
            @(negedge clk);
            cyc++;
            if (done_o === 1'b1) seen = 1'b1;
        end
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({tag, " idle_after_done"}, {30'd0, busy_o, cpu_hold_o}, 32'd0);
    endtask

    // Reference: word i is bytes 4i..4i+3 MSB first, written at (base+i) mod 2^16.
    task automatic verify_load(input logic [15:0] base, input logic [15:0] len,
                               input bit chk_rate, input string tag);
        logic [31:0] exp_sum = 32'd0;
        logic [31:0] w;
        logic [15:0] a;
        check({tag, " n_writes"}, 32'(wr_addr.size()), 32'(len));
        check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        for (int i = 0; i < int'(len); i++) begin
            w = {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
            a = 16'((int'(base) + i) % 65536);
            exp_sum += w;
            if (i < wr_addr.size()) begin
                check($sformatf("%s addr[%0d]", tag, i), 32'(wr_addr[i]), 32'(a));
                check($sformatf("%s data[%0d]", tag, i), wr_data[i], w);
                check($sformatf("%s fetch[%0d]", tag, i),
                      tbmem.exists(int'(a)) ? tbmem[int'(a)] : 32'hxxxxxxxx, w);
                if (chk_rate && i > 0)
                    check($sformatf("%s spacing[%0d]", tag, i), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd5);
            end
        end
        check({tag, " checksum"}, checksum_o, exp_sum);
    endtask

    initial begin
        logic [15:0] rb;
        logic [15:0] rl;
        rst          = 1'b1;
        start_i      = 1'b0;
        base_addr_i  = 16'd0;
        len_i        = 16'd0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'd0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            start_i      = 1'($urandom);
            byte_valid_i = 1'($urandom);
            byte_data_i  = 8'($urandom);
            base_addr_i  = 16'($urandom);
            len_i        = 16'($urandom);
            @(negedge clk);
            check("rst ctrl", {27'd0, byte_ready_o, mem_we_o, busy_o, done_o, cpu_hold_o}, 32'd0);
            check("rst addr", 32'(mem_addr_o), 32'd0);
            check("rst data_sum", mem_data_o | checksum_o, 32'd0);
        end
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        check("post_rst idle", {29'd0, busy_o, cpu_hold_o, byte_ready_o}, 32'd0);

        // Basic load, continuous stream
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load(16'h0000, 16'd2, 0, 1'b0, "basic");
        verify_load(16'h0000, 16'd2, 1'b1, "basic");
        check("basic checksum_const", checksum_o, 32'hACF13568);

        // Same image with three idle cycles before each byte
        run_load(16'h0000, 16'd2, 3, 1'b0, "stall");
        verify_load(16'h0000, 16'd2, 1'b0, "stall");

        // Address wrap
        img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        run_load(16'hFFFF, 16'd2, 0, 1'b0, "wrap");
        verify_load(16'hFFFF, 16'd2, 1'b1, "wrap");
        check("wrap checksum_const", checksum_o, 32'h00000003);

        // Zero length: done the cycle after start, no writes, checksum cleared
        clear_log();
        start_i     = 1'b1;
        base_addr_i = 16'h1234;
        len_i       = 16'd0;
        @(negedge clk);
        start_i = 1'b0;
        check("zero done", {30'd0, done_o, busy_o}, 32'd3);
        check("zero ready", 32'(byte_ready_o), 32'd0);
        @(negedge clk);
        check("zero done_once", {30'd0, done_o, busy_o}, 32'd0);
        check("zero n_writes", 32'(wr_addr.size()), 32'd0);
        check("zero checksum", checksum_o, 32'd0);

        // Start pulsed mid-load is ignored
        make_img(3);
        run_load(16'h0100, 16'd3, 0, 1'b1, "midstart");
        verify_load(16'h0100, 16'd3, 1'b1, "midstart");

        // Reset after two bytes of the first word
        clear_log();
        start_i     = 1'b1;
        base_addr_i = 16'h0020;
        len_i       = 16'd3;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            byte_valid_i = 1'b1;
            byte_data_i  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid_i = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst ctrl", {27'd0, byte_ready_o, mem_we_o, busy_o, done_o, cpu_hold_o}, 32'd0);
        check("midrst outs", {16'd0, mem_addr_o} | mem_data_o | checksum_o, 32'd0);
        @(negedge clk);
        check("midrst n_writes", 32'(wr_addr.size()), 32'd0);
        make_img(1);
        run_load(16'h0010, 16'd1, 0, 1'b0, "after_rst");
        verify_load(16'h0010, 16'd1, 1'b0, "after_rst");

        // Random loads, random byte gaps, sometimes near the wrap point
        for (int t = 0; t < 6; t++) begin
            rb = (t % 2 == 0) ? 16'($urandom) : 16'(16'hFFFD + 16'($urandom_range(2)));
            rl = 16'($urandom_range(5, 1));
            make_img(int'(rl));
            run_load(rb, rl, -1, 1'($urandom), $sformatf("rand%0d", t));
            verify_load(rb, rl, 1'b0, $sformatf("rand%0d", t));
        end

        check("invariants", 32'(inv_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
